// File: rtl/jk_reg_bank_if.sv
// Bus bundle for jk_reg_bank: control/data toward the bank, state back out.
// When JK_REG_BANK_CHANGE_EN is defined the bundle also carries the `changed` flag.
interface jk_reg_bank_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic             sin;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] nq;
    logic             sout;
`ifdef JK_REG_BANK_CHANGE_EN
    logic             changed;
`endif

    modport master (
        output en, mode, j, k, sin,
`ifdef JK_REG_BANK_CHANGE_EN
        input  changed,
`endif
        input  q, nq, sout
    );

    modport slave (
        input  en, mode, j, k, sin,
`ifdef JK_REG_BANK_CHANGE_EN
        output changed,
`endif
        output q, nq, sout
    );
endinterface

// File: rtl/jk_reg_bank.sv
// Parametrised bank of JK-style bits with JK / D-load / toggle / shift-left modes.
// Optional JK_REG_BANK_CHANGE_EN adds a registered `changed` flag on the bus.

// Next-state logic for a single storage bit; shift_in is the neighbour below (or sin).
module jk_reg_bit (
    input  logic       q_cur,
    input  logic       j,
    input  logic       k,
    input  logic       shift_in,
    input  logic       en,
    input  logic [1:0] mode,
    output logic       q_nxt
);
    localparam logic [1:0] MODE_JK    = 2'b00;
    localparam logic [1:0] MODE_LOAD  = 2'b01;
    localparam logic [1:0] MODE_TGL   = 2'b10;
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    always_comb begin
        q_nxt = q_cur;
        if (en) begin
            case (mode)
                MODE_JK:    q_nxt = (j & ~q_cur) | (~k & q_cur);
                MODE_LOAD:  q_nxt = j;
                MODE_TGL:   q_nxt = q_cur ^ j;
                MODE_SHIFT: q_nxt = shift_in;
                default:    q_nxt = q_cur;
            endcase
        end
    end
endmodule

module jk_reg_bank #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic         clk,
    input  logic         rst,
    jk_reg_bank_if.slave bus
);
    localparam logic [1:0] MODE_SHIFT = 2'b11;

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] shift_src;
    logic             sout_q, sout_d;

    // Bit 0 takes sin, every other bit takes its lower neighbour; works for WIDTH=1 too.
    always_comb begin
        shift_src    = q_q << 1;
        shift_src[0] = bus.sin;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_reg_bit u_bit (
            .q_cur    (q_q[i]),
            .j        (bus.j[i]),
            .k        (bus.k[i]),
            .shift_in (shift_src[i]),
            .en       (bus.en),
            .mode     (bus.mode),
            .q_nxt    (q_d[i])
        );
    end

    // sout only moves on a shift; every other mode leaves it alone.
    always_comb begin
        sout_d = sout_q;
        if (bus.en && bus.mode == MODE_SHIFT)
            sout_d = q_q[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= RESET_VAL;
            sout_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            sout_q <= sout_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.nq   = ~q_q;
    assign bus.sout = sout_q;

`ifdef JK_REG_BANK_CHANGE_EN
    logic changed_q, changed_d;

    // Reset loads are deliberately not reported as a change.
    always_comb begin
        changed_d = (q_d != q_q);
    end

    always_ff @(posedge clk) begin
        if (rst) changed_q <= 1'b0;
        else     changed_q <= changed_d;
    end

    assign bus.changed = changed_q;
`endif
endmodule

// File: tb/tb_jk_reg_bank.sv
// Randomised + directed bench for jk_reg_bank; a behavioural model feeds a scoreboard queue.
`timescale 1ns/1ps
module tb_jk_reg_bank;
    localparam int         W  = 8;
    localparam logic [7:0] RV = 8'hA5;

    typedef struct {
        logic [7:0] q;
        logic       sout;
        logic       chg;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    jk_reg_bank_if #(.WIDTH(W)) bus ();

    jk_reg_bank #(.WIDTH(W), .RESET_VAL(RV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_q;
    logic       m_sout;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Apply one cycle of inputs, predict the state after the coming edge, queue it.
    task automatic step(input logic r, input logic e, input logic [1:0] md,
                        input logic [7:0] jj, input logic [7:0] kk, input logic s);
        exp_t       x;
        logic [7:0] nx;
        logic       ns;
        rst = r; bus.en = e; bus.mode = md; bus.j = jj; bus.k = kk; bus.sin = s;
        nx = m_q;
        ns = m_sout;
        if (r) begin
            nx = RV;
            ns = 1'b0;
        end else if (e) begin
            case (md)
                2'd0: for (int i = 0; i < W; i++) begin
                    if (jj[i] && kk[i]) nx[i] = ~m_q[i];
                    else if (jj[i])     nx[i] = 1'b1;
                    else if (kk[i])     nx[i] = 1'b0;
                end
                2'd1: nx = jj;
                2'd2: nx = m_q ^ jj;
                default: begin
                    nx = 8'((m_q * 2) + s);
                    ns = m_q[7];
                end
            endcase
        end
        x.q    = nx;
        x.sout = ns;
        x.chg  = !r && (nx != m_q);
        sb.push_back(x);
        m_q    = nx;
        m_sout = ns;
        @(negedge clk);
    endtask

    // Monitor: the bank presents a fresh state every edge; compare just after it.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk("q", bus.q, x.q);
                chk("nq", bus.nq, ~x.q);
                chk("sout", {7'd0, bus.sout}, {7'd0, x.sout});
`ifdef JK_REG_BANK_CHANGE_EN
                chk("changed", {7'd0, bus.changed}, {7'd0, x.chg});
`endif
            end
        end
    end

    initial begin
        int waited;
        // Reset, then en=0 hold with random controls.
        step(1, 0, 2'd0, 8'h00, 8'h00, 0);
        for (int i = 0; i < 5; i++)
            step(0, 0, 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        // JK sequence from 00.
        step(0, 1, 2'd1, 8'h00, 8'h00, 0);
        step(0, 1, 2'd0, 8'hF0, 8'h00, 0);
        step(0, 1, 2'd0, 8'hFF, 8'hFF, 0);
        step(0, 1, 2'd0, 8'h00, 8'h0C, 0);
        // D-load then toggle.
        step(0, 1, 2'd1, 8'h3C, 8'hFF, 0);
        step(0, 1, 2'd2, 8'hFF, 8'h00, 0);
        step(0, 1, 2'd2, 8'h00, 8'hFF, 0);
        // Shift from 81, then sout must hold in toggle mode.
        step(0, 1, 2'd1, 8'h81, 8'h00, 0);
        step(0, 1, 2'd3, 8'h00, 8'h00, 1);
        step(0, 1, 2'd3, 8'h00, 8'h00, 0);
        step(0, 1, 2'd2, 8'h00, 8'h00, 1);
        // Shift stream interrupted by reset on the 3rd edge.
        step(0, 1, 2'd1, 8'hFF, 8'h00, 0);
        step(0, 1, 2'd3, 8'h00, 8'h00, 1);
        step(0, 1, 2'd3, 8'h00, 8'h00, 0);
        step(1, 1, 2'd3, 8'h00, 8'h00, 1);
        step(0, 1, 2'd3, 8'h00, 8'h00, 1);
        step(0, 1, 2'd3, 8'h00, 8'h00, 0);
        // Change-flag cases: single-bit toggle, zero mask, reload of same value.
        step(0, 1, 2'd2, 8'h01, 8'h00, 0);
        step(0, 1, 2'd2, 8'h00, 8'h00, 0);
        step(0, 1, 2'd1, m_q, 8'h00, 0);
        // Reset when RESET_VAL differs from current q.
        step(0, 1, 2'd1, 8'h00, 8'h00, 0);
        step(1, 1, 2'd2, 8'hFF, 8'h00, 0);
        // Random traffic with occasional resets and enables dropping.
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, 4) != 0),
                 2'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
